// File: rtl/regout_bank.sv
// Read-out buffer for NPU results. It captures a batch of multi-lane words and
// then lets two toggle buttons browse the batch one lane at a time.
module regout_bank #(
  parameter int LANES  = 4,
  parameter int LANE_W = 8,
  parameter int DEPTH  = 16,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic                                          clk,
  input  logic                                          rst,
  input  logic                                          in_valid,
  input  logic [LANES*LANE_W-1:0]                       in_data,
  input  logic                                          s,
  input  logic                                          p_button,
  input  logic                                          s_button,
  output logic [LANE_W-1:0]                             out,
  output logic                                          out_valid,
  output logic [AW-1:0]                                 word_idx,
  output logic [((LANES > 1) ? $clog2(LANES) : 1)-1:0]  lane_idx,
  output logic [AW:0]                                   count,
  output logic                                          full,
  output logic                                          overflow
);

  localparam int LIW = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int WW  = LANES * LANE_W;

  typedef enum logic {CAPTURE = 1'b0, DISPLAY = 1'b1} mode_t;

  mode_t             mode_q, mode_d;
  logic [1:0]        p_sync_q, s_sync_q;  // [0] = first flop, [1] = second flop
  logic [AW:0]       count_q, count_d;
  logic [AW-1:0]     word_q, word_d;
  logic [LIW-1:0]    lane_q, lane_d;
  logic              ovf_q, ovf_d;
  logic [LANE_W-1:0] out_q, out_d;
  logic              out_valid_q, out_valid_d;
  logic [WW-1:0]     mem_q [DEPTH];

  logic              p_evt, s_evt, full_w, wr_en, browse;
  logic [AW-1:0]     last_word, word_adv;
  logic [WW-1:0]     rd_word;
  logic [LANE_W-1:0] rd_lane;

  assign p_evt  = p_sync_q[0] ^ p_sync_q[1];
  assign s_evt  = s_sync_q[0] ^ s_sync_q[1];
  assign full_w = (count_q == (AW+1)'(DEPTH));
  assign wr_en  = (mode_q == CAPTURE) && in_valid && !full_w && !rst;
  assign browse = (mode_q == DISPLAY) && (count_q != '0);

  // Word advance wraps at the last captured word, not at the end of storage.
  assign last_word = AW'(count_q - (AW+1)'(1));
  assign word_adv  = (word_q == last_word) ? '0 : word_q + AW'(1);

  // Lane 0 sits in the most significant bits of the stored word.
  always_comb begin
    rd_word = mem_q[word_q];
    rd_lane = '0;
    for (int l = 0; l < LANES; l++) begin
      if (lane_q == LIW'(l)) rd_lane = rd_word[(LANES-1-l)*LANE_W +: LANE_W];
    end
  end

  always_comb begin
    // NOTE: every variable gets its hold value first, so no branch can infer a latch.
    mode_d  = s ? DISPLAY : CAPTURE;
    count_d = count_q;
    word_d  = word_q;
    lane_d  = lane_q;
    ovf_d   = ovf_q;
    if (mode_q == DISPLAY && mode_d == CAPTURE) begin
      count_d = '0;
      word_d  = '0;
      lane_d  = '0;
      ovf_d   = 1'b0;
    end else if (mode_q == CAPTURE) begin
      if (in_valid) begin
        if (full_w) ovf_d = 1'b1;
        else        count_d = count_q + (AW+1)'(1);
      end
      if (mode_d == DISPLAY) begin
        word_d = '0;
        lane_d = '0;
      end
    end else if (count_q != '0) begin
      if (p_evt) begin
        word_d = word_adv;
        lane_d = '0;
      end else if (s_evt) begin
        if (lane_q == LIW'(LANES - 1)) begin
          lane_d = '0;
          word_d = word_adv;
        end else begin
          lane_d = lane_q + LIW'(1);
        end
      end
    end
    out_valid_d = browse;
    out_d       = browse ? rd_lane : '0;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q      <= CAPTURE;
      p_sync_q    <= {p_button, p_button};
      s_sync_q    <= {s_button, s_button};
      count_q     <= '0;
      word_q      <= '0;
      lane_q      <= '0;
      ovf_q       <= 1'b0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      mode_q      <= mode_d;
      p_sync_q    <= {p_sync_q[0], p_button};
      s_sync_q    <= {s_sync_q[0], s_button};
      count_q     <= count_d;
      word_q      <= word_d;
      lane_q      <= lane_d;
      ovf_q       <= ovf_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
    end
  end

  // NOTE: the storage array has no reset; count_q alone decides which entries are live.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[count_q[AW-1:0]] <= in_data;
  end

  assign out       = out_q;
  assign out_valid = out_valid_q;
  assign word_idx  = word_q;
  assign lane_idx  = lane_q;
  assign count     = count_q;
  assign full      = full_w;
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_regout_bank.sv
// Bench for regout_bank: directed vector table, hand-written timing sequences and
// a randomized run against a queue-based behavioural model.
module tb_regout_bank;

  localparam int LANES  = 4;
  localparam int LANE_W = 8;
  localparam int DEPTH  = 16;
  localparam int AW     = 4;
  localparam int LIW    = 2;
  localparam int WW     = LANES * LANE_W;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              in_valid = 1'b0;
  logic [WW-1:0]     in_data = '0;
  logic              s = 1'b0;
  logic              p_button = 1'b0;
  logic              s_button = 1'b0;
  logic [LANE_W-1:0] out;
  logic              out_valid;
  logic [AW-1:0]     word_idx;
  logic [LIW-1:0]    lane_idx;
  logic [AW:0]       count;
  logic              full;
  logic              overflow;

  int n_checks = 0;
  int n_errors = 0;

  regout_bank #(.LANES(LANES), .LANE_W(LANE_W), .DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .s(s),
    .p_button(p_button), .s_button(s_button), .out(out), .out_valid(out_valid),
    .word_idx(word_idx), .lane_idx(lane_idx), .count(count), .full(full),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  // Behavioural model: the batch is a queue, indices are plain integers.
  logic [WW-1:0]     m_words [$];
  bit                m_display;
  int                m_word, m_lane;
  bit                m_ovf, m_valid;
  logic [LANE_W-1:0] m_out;
  bit                m_p1, m_p2, m_s1, m_s2;

  function automatic logic [LANE_W-1:0] lane_of(input logic [WW-1:0] w, input int lane);
    logic [WW-1:0] sh;
    sh = w >> ((LANES - 1 - lane) * LANE_W);
    return sh[LANE_W-1:0];
  endfunction

  always @(posedge clk) begin : model
    bit pe, se;
    int n;
    if (rst) begin
      m_words.delete();
      m_display = 0; m_word = 0; m_lane = 0; m_ovf = 0; m_valid = 0; m_out = '0;
      m_p1 = p_button; m_p2 = p_button; m_s1 = s_button; m_s2 = s_button;
    end else begin
      n       = m_words.size();
      m_valid = m_display && (n > 0);
      m_out   = m_valid ? lane_of(m_words[m_word], m_lane) : '0;
      pe      = (m_p1 != m_p2);
      se      = (m_s1 != m_s2);
      if (m_display && !s) begin
        m_words.delete();
        m_word = 0; m_lane = 0; m_ovf = 0;
      end else if (!m_display) begin
        if (in_valid) begin
          if (n < DEPTH) m_words.push_back(in_data);
          else           m_ovf = 1;
        end
        if (s) begin m_word = 0; m_lane = 0; end
      end else if (n > 0) begin
        if (pe) begin
          m_word = (m_word + 1) % n;
          m_lane = 0;
        end else if (se) begin
          m_lane = m_lane + 1;
          if (m_lane == LANES) begin
            m_lane = 0;
            m_word = (m_word + 1) % n;
          end
        end
      end
      m_display = s;
      m_p2 = m_p1; m_p1 = p_button;
      m_s2 = m_s1; m_s1 = s_button;
    end
  end

  typedef struct {
    bit                tog_p;
    bit                tog_s;
    logic [LANE_W-1:0] e_out;
    int                e_word;
    int                e_lane;
  } vec_t;

  localparam int NV = 12;
  vec_t vecs [NV];

  logic [LANE_W-1:0] seq_out [4];
  logic [WW-1:0]     batch [3];

  initial begin
    // Browse table over batch C0000000 / A8A00000 / 908C8000, starting at word 1 lane 0.
    vecs[0]  = '{1'b0, 1'b1, 8'hA0, 1, 1};
    vecs[1]  = '{1'b0, 1'b1, 8'h00, 1, 2};
    vecs[2]  = '{1'b1, 1'b0, 8'h90, 2, 0};
    vecs[3]  = '{1'b1, 1'b0, 8'hC0, 0, 0};
    vecs[4]  = '{1'b0, 1'b1, 8'h00, 0, 1};
    vecs[5]  = '{1'b1, 1'b1, 8'hA8, 1, 0};
    vecs[6]  = '{1'b0, 1'b1, 8'hA0, 1, 1};
    vecs[7]  = '{1'b1, 1'b0, 8'h90, 2, 0};
    vecs[8]  = '{1'b0, 1'b1, 8'h8C, 2, 1};
    vecs[9]  = '{1'b0, 1'b1, 8'h80, 2, 2};
    vecs[10] = '{1'b0, 1'b1, 8'h00, 2, 3};
    vecs[11] = '{1'b0, 1'b1, 8'hC0, 0, 0};
    seq_out[0] = 8'h00; seq_out[1] = 8'h00; seq_out[2] = 8'h00; seq_out[3] = 8'hA8;
    batch[0] = 32'hC000_0000; batch[1] = 32'hA8A0_0000; batch[2] = 32'h908C_8000;

    // Reset state
    ticks(2);
    rst = 1'b0;
    check("rst out", out, 0);
    check("rst out_valid", out_valid, 0);
    check("rst word_idx", word_idx, 0);
    check("rst lane_idx", lane_idx, 0);
    check("rst count", count, 0);
    check("rst full", full, 0);
    check("rst overflow", overflow, 0);

    // Capture three words, then enter display
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_data  = batch[i];
      tick();
    end
    in_valid = 1'b0;
    s = 1'b1;
    ticks(2);
    check("disp count", count, 3);
    check("disp out", out, 8'hC0);
    check("disp out_valid", out_valid, 1);
    check("disp word_idx", word_idx, 0);
    check("disp lane_idx", lane_idx, 0);

    // Back-to-back step events, one per cycle; out trails each toggle by three edges
    for (int i = 0; i < 6; i++) begin
      if (i < 4) s_button = ~s_button;
      tick();
      if (i >= 2) check($sformatf("step seq out %0d", i - 2), out, seq_out[i-2]);
    end
    check("step seq word_idx", word_idx, 1);
    check("step seq lane_idx", lane_idx, 0);

    // Vector table
    for (int i = 0; i < NV; i++) begin
      if (vecs[i].tog_p) p_button = ~p_button;
      if (vecs[i].tog_s) s_button = ~s_button;
      ticks(3);
      check($sformatf("vec%0d out", i), out, vecs[i].e_out);
      check($sformatf("vec%0d word_idx", i), word_idx, vecs[i].e_word);
      check($sformatf("vec%0d lane_idx", i), lane_idx, vecs[i].e_lane);
    end

    // Leave display: counters clear at once, out_valid one edge later
    s = 1'b0;
    tick();
    check("exit count", count, 0);
    check("exit overflow", overflow, 0);
    check("exit out_valid lag", out_valid, 1);
    tick();
    check("exit out_valid", out_valid, 0);
    check("exit out", out, 0);

    // Fill to DEPTH and one more
    for (int i = 0; i < 17; i++) begin
      in_valid = 1'b1;
      in_data  = WW'(i);
      tick();
      if (i == 14) check("fill15 full", full, 0);
      if (i == 15) begin
        check("fill16 full", full, 1);
        check("fill16 count", count, 16);
        check("fill16 overflow", overflow, 0);
      end
      if (i == 16) begin
        check("fill17 overflow", overflow, 1);
        check("fill17 count", count, 16);
      end
    end
    in_valid = 1'b0;
    s = 1'b1;
    ticks(2);
    check("full disp out", out, 8'h00);
    for (int i = 0; i < 15; i++) begin
      p_button = ~p_button;
      ticks(3);
    end
    check("full page word_idx", word_idx, 15);
    for (int i = 0; i < 3; i++) begin
      s_button = ~s_button;
      ticks(3);
    end
    check("last word lane3 out", out, 8'h0F);
    check("last word lane_idx", lane_idx, 3);
    s_button = ~s_button;
    ticks(3);
    check("wrap at DEPTH word_idx", word_idx, 0);
    check("wrap at DEPTH out", out, 8'h00);

    // Reset mid-display while both buttons go to 1 at the reset edge
    p_button = 1'b0;
    s_button = 1'b0;
    ticks(3);
    rst = 1'b1;
    p_button = 1'b1;
    s_button = 1'b1;
    tick();
    rst = 1'b0;
    check("mid rst out", out, 0);
    check("mid rst out_valid", out_valid, 0);
    check("mid rst word_idx", word_idx, 0);
    check("mid rst lane_idx", lane_idx, 0);
    check("mid rst count", count, 0);
    check("mid rst overflow", overflow, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("post rst idx %0d", i), {word_idx, lane_idx}, 0);
    end
    s = 1'b0;
    tick();
    in_valid = 1'b1;
    in_data  = 32'h1122_3344;
    tick();
    in_data  = 32'h5566_7788;
    tick();
    in_valid = 1'b0;
    s = 1'b1;
    ticks(2);
    check("recap out", out, 8'h11);
    check("recap count", count, 2);
    p_button = ~p_button;
    ticks(3);
    check("recap page out", out, 8'h55);

    // Randomized run against the model
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(39) == 0) s = ~s;
      if ($urandom_range(3) == 0) p_button = ~p_button;
      if ($urandom_range(2) == 0) s_button = ~s_button;
      in_valid = 1'($urandom_range(1));
      in_data  = $urandom();
      rst      = ($urandom_range(599) == 0);
      tick();
      check("rnd out", out, m_out);
      check("rnd out_valid", out_valid, m_valid);
      check("rnd word_idx", word_idx, m_word);
      check("rnd lane_idx", lane_idx, m_lane);
      check("rnd count", count, m_words.size());
      check("rnd full", full, m_words.size() == DEPTH);
      check("rnd overflow", overflow, m_ovf);
    end
    rst = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/regout_bank.md
Name: regout_bank

Overview:
- Parametrised NPU result read-out buffer. It captures a batch of multi-lane result words from the array output, then lets a user step through them one lane at a time for display.
- Two level-toggle buttons drive the browsing. The step button advances the lane; the page button advances the word.
- Sits between the NPU output stage and the board display driver. Replaces the fixed 32-bit/8-bit output register with configurable lane count, lane width and depth, plus occupancy/overflow status.

Parameters:
- LANES, 4, lanes per input word
- LANE_W, 8, bits per lane; equals the display width
- DEPTH, 16, words stored; power of two, at least 2
- AW, $clog2(DEPTH), word index width

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  capture strobe for in_data
- in_data  in  LANES*LANE_W  result word; lane 0 = MSBs
- s  in  1  mode select: 0 = capture, 1 = display
- p_button  in  1  page button, level toggle; every change is one event
- s_button  in  1  step button, level toggle; every change is one event
- out  out  LANE_W  selected lane of the selected word
- out_valid  out  1  out holds stored data
- word_idx  out  AW  current display word
- lane_idx  out  $clog2(LANES) (min 1)  current display lane
- count  out  AW+1  words captured in this batch
- full  out  1  count == DEPTH
- overflow  out  1  sticky: a write was attempted while full

Behaviour:
- Reset (rst=1 at an edge):
  - count, word_idx, lane_idx, out, out_valid, overflow all go to 0; mode register goes to capture.
  - Button history registers load the current button levels, so no spurious event follows reset.
  - Memory contents are don't-care.
- Button synchronisation:
  - Each button passes through two flops, b1 then b2. event = b1 ^ b2.
  - A toggle sampled at edge k gives an event during cycle k→k+1.
  - Indices update at edge k+1; out updates at edge k+2.
- States: CAPTURE (s_q=0), DISPLAY (s_q=1). s is registered as s_q.
- DISPLAY→CAPTURE (s_q falls):
  - count, word_idx, lane_idx and overflow clear at that edge; a new batch starts.
  - out_valid drops one edge later.
- CAPTURE→DISPLAY (s_q rises):
  - word_idx and lane_idx clear to 0.
  - Button events are ignored in the same cycle.
- CAPTURE:
  - in_valid with count<DEPTH: mem[count] <= in_data; count increments.
  - in_valid with count==DEPTH: data dropped; overflow set.
  - Button events are ignored; out holds 0 and out_valid=0.
- DISPLAY with count==0: events ignored; out=0, out_valid=0.
- DISPLAY with count>0:
  - s event: lane_idx increments. At LANES-1 it wraps to 0 and word_idx advances.
  - p event: word_idx advances; lane_idx goes to 0.
  - "Advance" means word_idx+1, wrapping to 0 at count-1 (not DEPTH-1).
  - Simultaneous p and s events: p wins; the s event is discarded.
- Output mapping:
  - out <= mem[word_idx][(LANES-1-lane_idx)*LANE_W +: LANE_W], registered.
  - Lane 0 is the most significant lane.
  - out_valid <= 1.
- in_valid during DISPLAY is ignored; memory is frozen.
- full is combinational from count.
- Reset mid-display or mid-capture discards the batch; state is identical to power-up reset.

Test Plan:
- Default params. Capture C0000000, A8A00000, 908C8000 with s=0, then s=1.
  → count=3. Two edges after s_q rises: out=C0, out_valid=1, word_idx=0, lane_idx=0.
- Same batch, toggle s_button 4 times, one event per cycle.
  → out sequence 00, 00, 00, then A8; word_idx=1, lane_idx=0 after the 4th event.
- Same batch, at word 1 lane 2, toggle p_button.
  → word_idx=2, lane_idx=0, out=90. Toggle again → word_idx wraps to 0 (count=3), out=C0.
- Toggle p_button and s_button on the same edge at word 0 lane 1.
  → word_idx=1, lane_idx=0, out=A8 (p wins).
- Write 17 words 0..16 in capture.
  → full=1 after the 16th write, count=16, overflow=1. Displaying the last word shows value 15 in lane 3. Word 16 is absent.
- Assert rst for one cycle mid-display with both buttons held at 1.
  → all outputs 0. No index change on the following 3 cycles without toggles. Dropping s then recapturing starts at mem[0].
